// File: rtl/arith_mulsi_ext_seq.sv
// Sequential signed multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Operands are converted to magnitudes, multiplied one multiplier bit per
// cycle by shift-and-add, then the sign is applied in a single fix-up cycle.
module arith_mulsi_ext_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [WIDTH-1:0]   a_data,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [WIDTH-1:0]   b_data,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [WIDTH-1:0]   result_data,
   output logic [WIDTH-1:0]   result_hi_data
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [WIDTH-1:0]   ONE_W      = 1;
   localparam logic [2*WIDTH-1:0] ONE_2W     = 1;
   localparam logic [CW-1:0]      ONE_C      = 1;
   localparam logic [CW-1:0]      COUNT_INIT = CW'(WIDTH);

   logic [1:0]         state_reg,  state_next;
   logic [2*WIDTH-1:0] acc_reg,    acc_next;
   logic [2*WIDTH-1:0] mcand_reg,  mcand_next;
   logic [WIDTH-1:0]   mplier_reg, mplier_next;
   logic [CW-1:0]      count_reg,  count_next;
   logic               sign_reg,   sign_next;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               accept;
   logic               in_idle;

   // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1),
   // which fits in WIDTH unsigned bits, so there is no overflow case.
   assign a_mag = a_data[WIDTH-1] ? (~a_data + ONE_W) : a_data;
   assign b_mag = b_data[WIDTH-1] ? (~b_data + ONE_W) : b_data;

   assign in_idle = (state_reg == IDLE);
   // Each ready depends on the other operand's valid so both are taken together.
   assign a_ready = in_idle & b_valid;
   assign b_ready = in_idle & a_valid;
   assign accept  = in_idle & a_valid & b_valid;

   assign result_valid   = (state_reg == DONE);
   assign result_data    = result_valid ? acc_reg[WIDTH-1:0]       : '0;
   assign result_hi_data = result_valid ? acc_reg[2*WIDTH-1:WIDTH] : '0;

   // Next-state and datapath: load, shift-and-add, sign fix-up, hold result.
   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      count_next  = count_reg;
      sign_next   = sign_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               mcand_next  = {{WIDTH{1'b0}}, a_mag};
               mplier_next = b_mag;
               sign_next   = a_data[WIDTH-1] ^ b_data[WIDTH-1];
               acc_next    = '0;
               count_next  = COUNT_INIT;
               state_next  = BUSY;
            end
         end
         BUSY: begin
            // mcand_reg already carries the shift for the current bit index.
            if (mplier_reg[0]) begin
               acc_next = acc_reg + mcand_reg;
            end
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            count_next  = count_reg - ONE_C;
            if (count_reg == ONE_C) begin
               state_next = FIX;
            end
         end
         FIX: begin
            // Negating zero yields zero, so no negative-zero case arises.
            if (sign_reg) begin
               acc_next = ~acc_reg + ONE_2W;
            end
            state_next = DONE;
         end
         DONE: begin
            if (result_ready) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         count_reg  <= '0;
         sign_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         count_reg  <= count_next;
         sign_reg   <= sign_next;
      end
   end

endmodule
